// File: rtl/multiply_fp32.sv
// -----------------------------------------------------------------------------
// multiply_fp32
//   Pipelined IEEE-754 binary32 multiplier. Subnormal inputs are flushed to
//   zero, results are rounded to nearest-even, there are no subnormal outputs
//   and no exception flags. Fixed latency of 3 cycles, one issue per cycle.
//
// Ports
//   clk_i    in   1  clock, rising edge
//   rstn_i   in   1  asynchronous active-low reset
//   valid_i  in   1  A/B carry an operation this cycle
//   A, B     in  32  binary32 operands
//   Result   out 32  registered product, held between completions
//   done_o   out  1  one-cycle strobe: Result holds a freshly completed product
//
// Handshake: valid_i high at rising edge N issues one operation (there is no
// ready; the pipe never stalls). Exactly one done_o pulse follows, visible
// after rising edge N+3, with Result valid in that same cycle. Completions
// come out in issue order. A/B are don't-care while valid_i is low.
// -----------------------------------------------------------------------------
module multiply_fp32 (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        done_o
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------------------------------------------------------------------
  // Stage 1: operand capture, then unpack/classify and exponent sum
  // ---------------------------------------------------------------------------
  logic        in_valid;
  logic [31:0] in_a;
  logic [31:0] in_b;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) in_valid <= 1'b0;
    else         in_valid <= valid_i;
  end

  // Operands are only loaded when issued, so idle-cycle inputs never move them.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      in_a <= A;
      in_b <= B;
    end
  end

  logic [7:0]        exp_a, exp_b;
  logic [22:0]       frac_a, frac_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic              c_nan, c_inf, c_zero;
  logic signed [9:0] exp_sum;

  always_comb begin
    exp_a  = in_a[30:23];
    exp_b  = in_b[30:23];
    frac_a = in_a[22:0];
    frac_b = in_b[22:0];
    // exp == 0 covers both true zeros and flushed subnormals.
    zero_a = (exp_a == 8'h00);
    zero_b = (exp_b == 8'h00);
    inf_a  = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b  = (exp_b == 8'hFF) && (frac_b == 23'd0);
    nan_a  = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b  = (exp_b == 8'hFF) && (frac_b != 23'd0);
    // inf * 0 is invalid and folds into the NaN class.
    c_nan  = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
    c_inf  = inf_a | inf_b;
    c_zero = zero_a | zero_b;
    // Range is -125..381, so 10 signed bits hold it through later increments.
    exp_sum = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
  end

  logic              s1_valid;
  logic              s1_sign;
  logic signed [9:0] s1_exp;
  logic [23:0]       s1_man_a, s1_man_b;
  logic              s1_nan, s1_inf, s1_zero;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) s1_valid <= 1'b0;
    else         s1_valid <= in_valid;
  end

  always_ff @(posedge clk_i) begin
    s1_sign  <= in_a[31] ^ in_b[31];
    s1_exp   <= exp_sum;
    s1_man_a <= {1'b1, frac_a};
    s1_man_b <= {1'b1, frac_b};
    s1_nan   <= c_nan;
    s1_inf   <= c_inf;
    s1_zero  <= c_zero;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: 24x24 mantissa multiply
  // ---------------------------------------------------------------------------
  logic              s2_valid;
  logic              s2_sign;
  logic signed [9:0] s2_exp;
  logic [47:0]       s2_prod;
  logic              s2_nan, s2_inf, s2_zero;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) s2_valid <= 1'b0;
    else         s2_valid <= s1_valid;
  end

  always_ff @(posedge clk_i) begin
    s2_sign <= s1_sign;
    s2_exp  <= s1_exp;
    s2_prod <= {24'd0, s1_man_a} * {24'd0, s1_man_b};
    s2_nan  <= s1_nan;
    s2_inf  <= s1_inf;
    s2_zero <= s1_zero;
  end

  // ---------------------------------------------------------------------------
  // Stage 3: normalize, round to nearest-even, pack
  // ---------------------------------------------------------------------------
  logic [23:0]       norm_man;
  logic              guard, rnd, sticky, round_up;
  logic signed [9:0] norm_exp, final_exp;
  logic [24:0]       rounded;
  logic [22:0]       final_frac;
  logic [31:0]       packed_res;

  always_comb begin
    // Product of two [1,2) mantissas lies in [1,4): the MSB is bit 47 or 46.
    if (s2_prod[47]) begin
      norm_man = s2_prod[47:24];
      guard    = s2_prod[23];
      rnd      = s2_prod[22];
      sticky   = |s2_prod[21:0];
      norm_exp = s2_exp + 10'sd1;
    end else begin
      norm_man = s2_prod[46:23];
      guard    = s2_prod[22];
      rnd      = s2_prod[21];
      sticky   = |s2_prod[20:0];
      norm_exp = s2_exp;
    end

    // Round up above the halfway point, or exactly at it when the LSB is odd.
    round_up = guard & (rnd | sticky | norm_man[0]);
    rounded  = {1'b0, norm_man} + {24'd0, round_up};

    // A carry out of rounding means the mantissa became 1.000..0 x 2.
    final_exp  = norm_exp + $signed({9'd0, rounded[24]});
    final_frac = rounded[24] ? rounded[23:1] : rounded[22:0];

    if (s2_nan)                   packed_res = QNAN;
    else if (s2_inf)              packed_res = {s2_sign, 8'hFF, 23'd0};
    else if (s2_zero)             packed_res = {s2_sign, 31'd0};
    else if (final_exp <= 10'sd0) packed_res = {s2_sign, 31'd0};
    else if (final_exp >= 10'sd255) packed_res = {s2_sign, 8'hFF, 23'd0};
    else                          packed_res = {s2_sign, final_exp[7:0], final_frac};
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      done_o <= 1'b0;
      Result <= 32'd0;
    end else begin
      done_o <= s2_valid;
      // Result only moves on completions so it holds between done pulses.
      if (s2_valid) Result <= packed_res;
    end
  end

endmodule

// File: tb/tb_multiply_fp32.sv
// -----------------------------------------------------------------------------
// tb_multiply_fp32
//   Scoreboarded bench for multiply_fp32: directed corner vectors, paced and
//   back-to-back random traffic against an arithmetic reference model, and an
//   asynchronous reset while operations are in flight.
// -----------------------------------------------------------------------------
module tb_multiply_fp32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] Result;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  multiply_fp32 dut (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .valid_i (valid_i),
    .A       (A),
    .B       (B),
    .Result  (Result),
    .done_o  (done_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          stamp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;
  logic [31:0] last_res = 32'd0;

  // ---------------------------------------------------------------------------
  // Reference model: exact integer product, rounded by remainder comparison
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, k, s, be;
    logic sgn;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    longint unsigned p, q, rem, half;
    logic [31:0] r;
    ea  = int'(a[30:23]);
    eb  = int'(b[30:23]);
    sgn = a[31] ^ b[31];
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    a_inf  = (ea == 255) && (a[22:0] == 23'd0);
    b_inf  = (eb == 255) && (b[22:0] == 23'd0);
    a_nan  = (ea == 255) && (a[22:0] != 23'd0);
    b_nan  = (eb == 255) && (b[22:0] != 23'd0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if ((a_inf && b_zero) || (b_inf && a_zero)) return 32'h7FC0_0000;
    if (a_inf || b_inf) return {sgn, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {sgn, 31'd0};
    p = (64'd8388608 + 64'(a[22:0])) * (64'd8388608 + 64'(b[22:0]));
    k = 47;
    while (((p >> k) & 64'd1) == 64'd0) k--;
    s    = k - 23;
    q    = p >> s;
    rem  = p - (q << s);
    half = 64'd1 << (s - 1);
    if (rem > half || (rem == half && q[0])) q = q + 64'd1;
    if (q == 64'd16777216) begin
      q = q >> 1;
      k++;
    end
    be = k - 46 + ea + eb - 127;
    if (be <= 0)   return {sgn, 31'd0};
    if (be >= 255) return {sgn, 8'hFF, 23'd0};
    r = {sgn, be[7:0], q[22:0]};
    return r;
  endfunction

  // Operand generator weighted towards classes and exponent edges.
  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    int sel;
    r   = $urandom();
    sel = $urandom_range(0, 15);
    case (sel)
      0:  r[30:0]  = 31'd0;
      1:  begin r[30:23] = 8'hFF; r[22:0] = 23'd0; end
      2:  begin r[30:23] = 8'hFF; r[22] = 1'b1; end
      3:  r[30:23] = 8'h00;
      4:  r[30:23] = ($urandom_range(0, 1) == 0) ? 8'd1 : 8'd254;
      5:  begin r[30:23] = 8'(int'($urandom_range(120, 134))); r[22:0] = 23'h7FFFFF ^ 23'($urandom_range(0, 3)); end
      6:  r[30:23] = 8'(int'($urandom_range(180, 254)));
      7:  r[30:23] = 8'(int'($urandom_range(1, 70)));
      8, 9: ;
      default: r[30:23] = 8'(int'($urandom_range(100, 154)));
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (called right after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    valid_i = 1'b1;
    A = a;
    B = b;
    exp_q.push_back(e);
    stamp_q.push_back(cyc + 4);
    @(negedge clk_i);
    valid_i = 1'b0;
    A = $urandom();
    B = $urandom();
  endtask

  task automatic issue_rand();
    logic [31:0] a, b;
    a = rand_op();
    b = rand_op();
    issue(a, b, ref_mul(a, b));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops on every done pulse, checks value, latency and hold
  // ---------------------------------------------------------------------------
  always @(negedge clk_i) begin
    logic [31:0] e;
    int          st;
    if (!rstn_i) begin
      last_res = 32'd0;
    end else if (done_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_done: done_o=1 at cycle %0d with Result=%h, required no pulse", cyc, Result);
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        n_vec++;
        if (Result !== e) begin
          n_fail++;
          $display("FAIL result: got %h, required %h", Result, e);
        end
        n_vec++;
        if (cyc != st) begin
          n_fail++;
          $display("FAIL latency: done at cycle %0d, required cycle %0d", cyc, st);
        end
      end
      last_res = Result;
    end else begin
      n_vec++;
      if (done_o !== 1'b0 || Result !== last_res) begin
        n_fail++;
        $display("FAIL hold: done_o=%b Result=%h, required done_o=0 Result=%h", done_o, Result, last_res);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  logic [31:0] dir_a[13] = '{32'h0000_0000, 32'h2317_A4DB, 32'hBF80_0000, 32'h4000_0000,
                             32'h3F80_0001, 32'h3FC0_0000, 32'h7F00_0000, 32'h7F80_0000,
                             32'h7FC0_0000, 32'h0080_0000, 32'hFF80_0000, 32'h8000_0000,
                             32'h3FFF_FFFF};
  logic [31:0] dir_b[13] = '{32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h4040_0000,
                             32'h3F80_0001, 32'h3FC0_0000, 32'h4000_0000, 32'h0000_0000,
                             32'h3F80_0000, 32'h0080_0000, 32'h3F80_0000, 32'h7F80_0000,
                             32'h3FFF_FFFF};
  logic [31:0] dir_r[13] = '{32'h0000_0000, 32'h0000_0000, 32'hBF80_0000, 32'h40C0_0000,
                             32'h3F80_0002, 32'h4010_0000, 32'h7F80_0000, 32'h7FC0_0000,
                             32'h7FC0_0000, 32'h0000_0000, 32'hFF80_0000, 32'h7FC0_0000,
                             32'h407F_FFFE};

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    // Reset held across several edges; outputs must sit at zero.
    repeat (3) @(negedge clk_i);
    check_val("reset_done", {31'd0, done_o}, 32'd0);
    check_val("reset_result", Result, 32'd0);
    rstn_i = 1'b1;
    idle(3);
    check_val("post_reset_idle_result", Result, 32'd0);

    // Single issue, then silence: one pulse at latency 3 only.
    issue(32'h3F80_0000, 32'h3F98_8D00, 32'h3F98_8D00);
    idle(8);

    // Directed corners, paced every other cycle.
    for (int i = 0; i < 13; i++) begin
      issue(dir_a[i], dir_b[i], dir_r[i]);
      idle(1);
    end
    drain();

    // Eleven random pairs every other cycle, then a back-to-back burst.
    for (int i = 0; i < 11; i++) begin
      issue_rand();
      idle(1);
    end
    for (int i = 0; i < 60; i++) issue_rand();
    drain();

    // Random mix of gaps and bursts.
    for (int i = 0; i < 150; i++) begin
      issue_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    drain();

    // Async reset with two operations in flight.
    issue(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    drain();
    issue(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
    issue(32'hBF80_0000, 32'h4000_0000, 32'hC000_0000);
    #2 rstn_i = 1'b0;
    #1;
    check_val("async_reset_done", {31'd0, done_o}, 32'd0);
    check_val("async_reset_result", Result, 32'd0);
    exp_q.delete();
    stamp_q.delete();
    idle(3);
    #2 rstn_i = 1'b1;
    @(negedge clk_i);
    idle(6);
    check_val("flushed_result", Result, 32'd0);
    issue(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002);
    drain();
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
